seq_detector_param: RTL

- Parametrised successor to the fixed 8-bit serial pattern detector.
- Detects a runtime-loadable pattern of PAT_W bits on a 1-bit serial stream with in_valid qualification.
- Supports selectable overlapping or non-overlapping detection.
- Reports per-match pulses plus a per-window verdict every WIN_LEN cycles; sits between the serial receive front end and the status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_win_timer.sv | 85 ++++++++
 rtl/seq_detector_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and defaults for the serial pattern detector
// Contents: state_t (ST_IDLE, ST_FILL, ST_ARMED), PAT_W_DEF, WIN_LEN_DEF.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam int PAT_W_DEF   = 8;
  localparam int WIN_LEN_DEF = 40;

endpackage

// File: rtl/seq_win_timer.sv
// rtl/seq_win_timer.sv - observation window counter with per-window hit verdict
// Optional macro: SEQ_DET_MATCH_CNT_EN adds the saturating match_cnt output.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   run          detector armed; counter advances every cycle while high
//   restart      reconfiguration strobe; window restarts at 0, no win_done
//   hit          a match completes on this clock edge
//   win_done     1-cycle pulse after the counter's last value
//   win_hit      OR of hits in the finished window, held until next win_done
//   match_cnt    (optional) saturating hit count of the finished window
module seq_win_timer #(
  parameter int WIN_LEN = 40,
  parameter int WIN_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic             hit,
  output logic             win_done,
  output logic             win_hit
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [WIN_W-1:0] match_cnt
`endif
);

  logic [WIN_W-1:0] cnt;
  logic             acc;
  logic             last;

  assign last = (cnt == WIN_W'(WIN_LEN - 1));

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [WIN_W-1:0] cnt_acc;
  logic [WIN_W-1:0] cnt_sum;
  // Saturate at all-ones rather than wrapping.
  assign cnt_sum = (cnt_acc == '1) ? cnt_acc : cnt_acc + WIN_W'(hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_acc   <= '0;
      match_cnt <= '0;
    end else if (restart) begin
      cnt_acc <= '0;
    end else if (run) begin
      if (last) begin
        match_cnt <= cnt_sum;
        cnt_acc   <= '0;
      end else begin
        cnt_acc <= cnt_sum;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= 1'b0;
      win_done <= 1'b0;
      win_hit  <= 1'b0;
    end else if (restart) begin
      // Restart beats a coincident wrap: the old window is abandoned silently.
      cnt      <= '0;
      acc      <= 1'b0;
      win_done <= 1'b0;
      win_hit  <= 1'b0;
    end else if (run) begin
      if (last) begin
        cnt      <= '0;
        acc      <= 1'b0;
        win_done <= 1'b1;
        win_hit  <= acc | hit;  // a hit on the final cycle still belongs here
      end else begin
        cnt      <= cnt + WIN_W'(1);
        acc      <= acc | hit;
        win_done <= 1'b0;
      end
    end else begin
      win_done <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable serial pattern detector with windowed verdict
// Optional macro: SEQ_DET_MATCH_CNT_EN adds match_cnt [WIN_W-1:0].
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cfg_load                strobe latching cfg_pattern / cfg_overlap and (re)arming
//   cfg_pattern[PAT_W]      pattern, MSB received first
//   cfg_overlap             1 = overlapping matches allowed
//   seq_in, in_valid        serial data bit and its qualifier
//   match                   1-cycle pulse after the completing bit
//   win_done, win_hit       window end pulse and held window verdict
//   armed                   detector loaded and running
//   match_cnt               (optional) matches in the finished window
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int WIN_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             seq_in,
  input  logic             in_valid,
  output logic             match,
  output logic             win_done,
  output logic             win_hit,
  output logic             armed
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [WIN_W-1:0] match_cnt
`endif
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  state_t            state;
  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  hist_next;
  logic              active;
  logic              full_next;
  logic              hit;

  assign hist_next = {hist[PAT_W-2:0], seq_in};
  assign active    = (state != ST_IDLE);
  // With the current bit included, the history holds PAT_W fresh bits.
  assign full_next = (fill >= FILL_W'(PAT_W - 1));
  // cfg_load suppresses a coincident completing bit.
  assign hit       = active && !cfg_load && in_valid && full_next && (hist_next == pat_q);
  assign armed     = active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hist  <= '0;
      pat_q <= '0;
      ovl_q <= 1'b0;
      fill  <= '0;
      match <= 1'b0;
    end else if (cfg_load) begin
      state <= ST_FILL;
      hist  <= '0;
      pat_q <= cfg_pattern;
      ovl_q <= cfg_overlap;
      fill  <= '0;
      match <= 1'b0;
    end else if (active && in_valid) begin
      hist  <= hist_next;
      match <= hit;
      if (hit && !ovl_q) begin
        // Non-overlapping: next match must be built from fresh bits only.
        fill  <= '0;
        state <= ST_FILL;
      end else begin
        if (fill != FILL_W'(PAT_W)) fill <= fill + FILL_W'(1);
        if (full_next) state <= ST_ARMED;
      end
    end else begin
      match <= 1'b0;
    end
  end

  seq_win_timer #(
    .WIN_LEN (WIN_LEN),
    .WIN_W   (WIN_W)
  ) u_win_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (active),
    .restart   (cfg_load),
    .hit       (hit),
    .win_done  (win_done),
    .win_hit   (win_hit)
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

endmodule
